button_reader: RTL and testbench
================================

BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port btn_in, input, 1, raw asynchronous pushbutton pin, 1 = pressed.
REQ-005 SHALL have port ack, input, 1, host acknowledge of the pending event.
REQ-006 SHALL have port clr_ovf, input, 1, synchronous clear of the overflow flag.
REQ-007 SHALL have port btn_level, output, 1, debounced button state.
REQ-008 SHALL have port press_pulse, output, 1, one-cycle strobe on an accepted press.
REQ-009 SHALL have port release_pulse, output, 1, one-cycle strobe on an accepted release.
REQ-010 SHALL have port event_valid, output, 1, an event is pending for the host.
REQ-011 SHALL have port event_code, output, 1, pending event type: 1 = press, 0 = release.
REQ-012 SHALL have port press_count, output, 8, number of accepted presses modulo 256.
REQ-013 SHALL have port overflow, output, 1, sticky flag: an event was dropped.

Function
REQ-014 SHALL pass btn_in through a two-flop synchronizer; only the second flop output (sample) SHALL be used downstream.
REQ-015 SHALL implement a debounce FSM with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO, plus a 16-bit counter.
REQ-016 STABLE_LO: sample = 1 -> WAIT_HI, counter cleared to 1; otherwise remain.
REQ-017 WAIT_HI: sample = 0 -> STABLE_LO, counter cleared; sample = 1 with counter = DEBOUNCE_CYCLES-1 -> STABLE_HI; otherwise counter increments.
REQ-018 STABLE_HI and WAIT_LO SHALL mirror REQ-016/017 with the polarities swapped.
REQ-019 btn_level SHALL be 1 exactly in STABLE_HI and WAIT_LO.
REQ-020 Latency: a clean btn_in edge SHALL appear on btn_level 2 + DEBOUNCE_CYCLES clock edges later.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on any output.
REQ-022 press_pulse SHALL be high for exactly the one cycle in which btn_level first reads 1; release_pulse likewise when it first reads 0.
REQ-023 press_count SHALL increment on each press_pulse and wrap from 255 to 0 without other side effect.
REQ-024 On a press or release pulse with event_valid = 0: event_valid <= 1 and event_code <= event type, on the next edge.
REQ-025 event_valid SHALL hold, and event_code SHALL stay stable, until ack = 1 is sampled while event_valid = 1; event_valid SHALL then clear on that edge.
REQ-026 ack while event_valid = 0 SHALL be ignored.
REQ-027 New event with event_valid = 1 and ack = 0: the event SHALL be dropped, event_code kept, and overflow set to 1.
REQ-028 New event in the same cycle as ack with event_valid = 1: event_valid SHALL stay 1, event_code SHALL take the new event, and overflow SHALL be unchanged.
REQ-029 overflow SHALL clear on clr_ovf = 1; a simultaneous set condition SHALL win (overflow stays 1).

Reset
REQ-030 resetn = 0 SHALL immediately force the following, regardless of clk: FSM = STABLE_LO; counter, both synchronizer flops, btn_level, press_pulse, release_pulse, event_valid, event_code, press_count and overflow all 0.
REQ-031 Reset asserted in any WAIT state SHALL abandon the pending transition with no pulse.
REQ-032 A button held at reset deassertion SHALL be reported as a press 2 + DEBOUNCE_CYCLES cycles after deassertion.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Clean press: btn_in 0->1 held -> btn_level = 1 and press_pulse one cycle at edge 6; event_valid = 1, event_code = 1, press_count = 1.
REQ-034 Bounce: btn_in high 3 cycles, low 1, high held -> no output during the bounce; press accepted 6 edges after the final rise.
REQ-035 Handshake: press, no ack, then release -> overflow = 1, event_code still 1; ack -> event_valid = 0; clr_ovf -> overflow = 0.
REQ-036 Same-cycle ack plus new release event -> event_valid stays 1, event_code = 0, overflow = 0.
REQ-037 256 presses -> press_count = 0 and 256 press_pulse strobes.
REQ-038 resetn low mid-WAIT_HI -> all outputs 0 asynchronously; btn_in still high -> press reported 6 edges after release of reset.

Source files
------------

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced pushbutton reader with press/release events
// Synchronizes, debounces and reports button edges through a one-deep event holding register.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_in,
  input  logic       ack,
  input  logic       clr_ovf,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       event_valid,
  output logic       event_code,
  output logic [7:0] press_count,
  output logic       overflow
);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        sync_q, sample;
  logic        rise, fall, new_event;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 1'b0;
      sample <= 1'b0;
    end else begin
      sync_q <= btn_in;
      sample <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= STABLE_LO;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter tracks how many consecutive samples have agreed with the new level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: if (sample) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = 16'd1;
      end
      WAIT_HI: if (!sample) begin
        state_nxt = STABLE_LO;
        cnt_nxt   = 16'd0;
      end else if (cnt == LIMIT) begin
        state_nxt = STABLE_HI;
        cnt_nxt   = 16'd0;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
      STABLE_HI: if (!sample) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = 16'd1;
      end
      WAIT_LO: if (sample) begin
        state_nxt = STABLE_HI;
        cnt_nxt   = 16'd0;
      end else if (cnt == LIMIT) begin
        state_nxt = STABLE_LO;
        cnt_nxt   = 16'd0;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_comb begin
    btn_level = (state == STABLE_HI) || (state == WAIT_LO);
    rise      = (state == WAIT_HI) && (state_nxt == STABLE_HI);
    fall      = (state == WAIT_LO) && (state_nxt == STABLE_LO);
    new_event = press_pulse || release_pulse;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      if (press_pulse) press_count <= press_count + 8'd1;
    end
  end

  // An ack in the same cycle as a new event frees the slot for that event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      event_valid <= 1'b0;
      event_code  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (new_event) begin
        if (!event_valid || ack) begin
          event_valid <= 1'b1;
          event_code  <= press_pulse;
        end
      end else if (event_valid && ack) begin
        event_valid <= 1'b0;
      end
      if (new_event && event_valid && !ack) overflow <= 1'b1;
      else if (clr_ovf)                     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader
// Uses DEBOUNCE_CYCLES = 4, so a clean edge reaches btn_level 6 edges later.
module tb_button_reader;

  logic       clk = 1'b0;
  logic       resetn, btn_in, ack, clr_ovf;
  logic       btn_level, press_pulse, release_pulse, event_valid, event_code, overflow;
  logic [7:0] press_count;
  int         total = 0;
  int         bad = 0;
  int         strobes;

  button_reader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .ack(ack), .clr_ovf(clr_ovf),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_valid(event_valid), .event_code(event_code), .press_count(press_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; btn_in = 1'b0; ack = 1'b0; clr_ovf = 1'b0;
    #3;
    chk("rst_level", {7'd0, btn_level}, 8'd0);
    chk("rst_valid", {7'd0, event_valid}, 8'd0);
    chk("rst_count", press_count, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    tick(); tick();
    resetn = 1'b1;

    // clean press
    btn_in = 1'b1;
    repeat (5) tick();
    chk("press_early_level", {7'd0, btn_level}, 8'd0);
    tick();
    chk("press_level", {7'd0, btn_level}, 8'd1);
    chk("press_pulse", {7'd0, press_pulse}, 8'd1);
    tick();
    chk("press_pulse_end", {7'd0, press_pulse}, 8'd0);
    chk("press_valid", {7'd0, event_valid}, 8'd1);
    chk("press_code", {7'd0, event_code}, 8'd1);
    chk("press_count1", press_count, 8'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_clears", {7'd0, event_valid}, 8'd0);

    // clean release
    btn_in = 1'b0;
    repeat (6) tick();
    chk("rel_level", {7'd0, btn_level}, 8'd0);
    chk("rel_pulse", {7'd0, release_pulse}, 8'd1);
    tick();
    chk("rel_code", {7'd0, event_code}, 8'd0);
    ack = 1'b1; tick(); ack = 1'b0;

    // bounce: high 3, low 1, then held high
    btn_in = 1'b1;
    repeat (3) begin tick(); chk("bounce_lvl", {7'd0, btn_level}, 8'd0); end
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    repeat (5) begin
      tick();
      chk("bounce_lvl2", {7'd0, btn_level}, 8'd0);
      chk("bounce_pulse", {7'd0, press_pulse}, 8'd0);
    end
    tick();
    chk("bounce_accept", {7'd0, press_pulse}, 8'd1);
    tick();
    chk("bounce_count2", press_count, 8'd2);

    // unacknowledged press followed by release
    btn_in = 1'b0;
    repeat (7) tick();
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    chk("ovf_code_kept", {7'd0, event_code}, 8'd1);
    chk("ovf_valid", {7'd0, event_valid}, 8'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ovf_ack", {7'd0, event_valid}, 8'd0);
    chk("ovf_sticky", {7'd0, overflow}, 8'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clear", {7'd0, overflow}, 8'd0);

    // ack in the same cycle as a new release event
    btn_in = 1'b1;
    repeat (7) tick();
    chk("same_press_code", {7'd0, event_code}, 8'd1);
    btn_in = 1'b0;
    repeat (6) tick();
    chk("same_rel_pulse", {7'd0, release_pulse}, 8'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("same_valid", {7'd0, event_valid}, 8'd1);
    chk("same_code", {7'd0, event_code}, 8'd0);
    chk("same_ovf", {7'd0, overflow}, 8'd0);
    ack = 1'b1; tick(); ack = 1'b0;

    // 256 presses wrap the counter back to its starting value of 3
    strobes = 0;
    for (int i = 0; i < 256; i++) begin
      btn_in = 1'b1;
      repeat (7) begin tick(); if (press_pulse) strobes++; end
      btn_in = 1'b0;
      repeat (7) begin tick(); if (press_pulse) strobes++; end
    end
    chk("wrap_strobes_lo", strobes[7:0], 8'd0);
    chk("wrap_strobes_hi", strobes[15:8], 8'd1);
    chk("wrap_count", press_count, 8'd3);

    // reset in the middle of WAIT_HI with the button still held
    btn_in = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    #2;
    chk("async_count", press_count, 8'd0);
    chk("async_ovf", {7'd0, overflow}, 8'd0);
    chk("async_valid", {7'd0, event_valid}, 8'd0);
    chk("async_pulse", {7'd0, press_pulse}, 8'd0);
    tick();
    resetn = 1'b1;
    repeat (5) tick();
    chk("held_early", {7'd0, btn_level}, 8'd0);
    tick();
    chk("held_level", {7'd0, btn_level}, 8'd1);
    chk("held_pulse", {7'd0, press_pulse}, 8'd1);
    tick();
    chk("held_count", press_count, 8'd1);
    chk("held_valid", {7'd0, event_valid}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
